// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the brick-smash game-flow controller: the sequencer
// state encoding (also exported on the HUD/debug state bus), the brick-wall
// geometry and the playfield line below which the ball counts as lost.
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SERVE = 3'd2,
    PLAY  = 3'd3,
    LOST  = 3'd4,
    OVER  = 3'd5
  } state_e;

  localparam int BRICKS_H    = 16;
  localparam int BRICKS_V    = 8;
  localparam int BALL_Y_LOSS = 232;

endpackage

// File: rtl/game_sequencer_if.sv
// ---------------------------------------------------------------------------
// game_sequencer_if
// Bundles the signals between the game sequencer and the surrounding
// datapath (ball/paddle logic, brick array, player stats).
//   master : the sequencer side (takes frame/player/ball inputs, drives the
//            brick clear stream, ball gating, stats pulses, level and state)
//   slave  : the datapath side
// ---------------------------------------------------------------------------
interface game_sequencer_if #(
  parameter int IDX_W = 7
);
  logic             frame_tick;
  logic             fire;
  logic [8:0]       ball_y;
  logic             brick_hit;
  logic [3:0]       lives;
  logic             clr_we;
  logic [IDX_W-1:0] clr_idx;
  logic             ball_run;
  logic             ball_load;
  logic             declives;
  logic             reset_stats;
  logic [3:0]       level;
  logic [2:0]       state;

  modport master (
    input  frame_tick, fire, ball_y, brick_hit, lives,
    output clr_we, clr_idx, ball_run, ball_load, declives, reset_stats,
           level, state
  );

  modport slave (
    output frame_tick, fire, ball_y, brick_hit, lives,
    input  clr_we, clr_idx, ball_run, ball_load, declives, reset_stats,
           level, state
  );
endinterface

// File: rtl/frame_timer.sv
// ---------------------------------------------------------------------------
// frame_timer
// Loadable down-counter clocked by frame ticks; used for both the serve wait
// and the post-loss pause.
//   clk, reset    : clock, asynchronous active-high reset
//   i_load        : load i_load_val (wins over a simultaneous tick)
//   i_load_val    : frame count to wait
//   i_frame_tick  : one-clk pulse per video frame
//   o_done        : count is 0, or this tick takes it from 1 to 0
// ---------------------------------------------------------------------------
module frame_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_frame_tick,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_frame_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Flag the tick that reaches zero so the owner can switch state on that
  // same edge; a zero count (including zero on load) reads as expired.
  assign o_done = (r_count == '0) ||
                  (i_frame_tick && (r_count == CNT_W'(1)));

endmodule

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
// Game-flow controller: attract (IDLE), brick-wall refill (CLEAR), serve
// wait (SERVE), play (PLAY), life lost pause (LOST) and game over (OVER).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : game_sequencer_if.master
//     in  frame_tick, fire, ball_y[8:0], brick_hit, lives[3:0]
//     out clr_we, clr_idx[IDX_W-1:0], ball_run, ball_load, declives,
//         reset_stats, level[3:0], state[2:0]   (all registered)
// ---------------------------------------------------------------------------
module game_sequencer
  import game_pkg::*;
#(
  parameter int BRICKS       = game_pkg::BRICKS_H * game_pkg::BRICKS_V,
  parameter int IDX_W        = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int LOSS_FRAMES  = 90,
  parameter int BALL_Y_LOSS  = game_pkg::BALL_Y_LOSS,
  parameter int MAX_LEVEL    = 15
) (
  input logic               clk,
  input logic               reset,
  game_sequencer_if.master  bus
);

  localparam int CNT_MAX = (SERVE_FRAMES > LOSS_FRAMES) ? SERVE_FRAMES : LOSS_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           r_state, w_state;
  logic             r_clr_we, w_clr_we;
  logic [IDX_W-1:0] r_clr_idx, w_clr_idx;
  logic             r_ball_run, w_ball_run;
  logic             r_ball_load, w_ball_load;
  logic             r_declives, w_declives;
  logic             r_reset_stats, w_reset_stats;
  logic [3:0]       r_level, w_level;
  logic [IDX_W:0]   r_bricks_left, w_bricks_left;
  logic             r_seen_low, w_seen_low;   // OVER: fire seen released on a tick
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_done;

  frame_timer #(.CNT_W(CNT_W)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_tmr_load),
    .i_load_val   (w_tmr_val),
    .i_frame_tick (bus.frame_tick),
    .o_done       (w_tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_clr_we      <= 1'b0;
      r_clr_idx     <= '0;
      r_ball_run    <= 1'b0;
      r_ball_load   <= 1'b1;
      r_declives    <= 1'b0;
      r_reset_stats <= 1'b0;
      r_level       <= '0;
      r_bricks_left <= '0;
      r_seen_low    <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_clr_we      <= w_clr_we;
      r_clr_idx     <= w_clr_idx;
      r_ball_run    <= w_ball_run;
      r_ball_load   <= w_ball_load;
      r_declives    <= w_declives;
      r_reset_stats <= w_reset_stats;
      r_level       <= w_level;
      r_bricks_left <= w_bricks_left;
      r_seen_low    <= w_seen_low;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state       = r_state;
    w_clr_we      = 1'b0;
    w_clr_idx     = '0;
    w_declives    = 1'b0;
    w_reset_stats = 1'b0;
    w_level       = r_level;
    w_bricks_left = r_bricks_left;
    w_seen_low    = r_seen_low;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;

    unique case (r_state)
      IDLE: begin
        if (bus.frame_tick && bus.fire) begin
          w_state       = CLEAR;
          w_level       = '0;
          w_reset_stats = 1'b1;
          w_clr_we      = 1'b1;   // index 0 is written on the first CLEAR cycle
        end
      end

      CLEAR: begin
        if (r_clr_idx == IDX_W'(BRICKS - 1)) begin
          w_state       = SERVE;
          w_bricks_left = (IDX_W + 1)'(BRICKS);
          w_tmr_load    = 1'b1;
          w_tmr_val     = CNT_W'(SERVE_FRAMES);
        end else begin
          w_clr_we  = 1'b1;
          w_clr_idx = r_clr_idx + 1'b1;
        end
      end

      SERVE: begin
        if (w_tmr_done || (bus.frame_tick && bus.fire)) begin
          w_state = PLAY;
        end
      end

      PLAY: begin
        if (bus.brick_hit && (r_bricks_left != '0)) begin
          w_bricks_left = r_bricks_left - 1'b1;
        end
        // The last brick takes priority over a ball lost on the same cycle.
        if (bus.brick_hit && (r_bricks_left == (IDX_W + 1)'(1))) begin
          w_state  = CLEAR;
          w_clr_we = 1'b1;
          w_level  = (r_level >= 4'(MAX_LEVEL)) ? r_level : r_level + 1'b1;
        end else if (bus.frame_tick && (bus.ball_y >= 9'(BALL_Y_LOSS))) begin
          w_state    = LOST;
          w_declives = 1'b1;
          w_tmr_load = 1'b1;
          w_tmr_val  = CNT_W'(LOSS_FRAMES);
        end
      end

      LOST: begin
        if (w_tmr_done) begin
          if (bus.lives == '0) begin
            w_state    = OVER;
            w_seen_low = 1'b0;
          end else begin
            w_state    = SERVE;
            w_tmr_load = 1'b1;
            w_tmr_val  = CNT_W'(SERVE_FRAMES);
          end
        end
      end

      OVER: begin
        // A held button must be released on a frame before it can restart.
        if (bus.frame_tick) begin
          if (!bus.fire)       w_seen_low = 1'b1;
          else if (r_seen_low) w_state    = IDLE;
        end
      end

      default: w_state = IDLE;
    endcase

    w_ball_run  = (w_state == PLAY);
    w_ball_load = (w_state != PLAY) && (w_state != LOST);
  end

  assign bus.clr_we      = r_clr_we;
  assign bus.clr_idx     = r_clr_idx;
  assign bus.ball_run    = r_ball_run;
  assign bus.ball_load   = r_ball_load;
  assign bus.declives    = r_declives;
  assign bus.reset_stats = r_reset_stats;
  assign bus.level       = r_level;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer
// Directed bench for game_sequencer. The expected brick-clear index stream is
// queued when a refill is triggered and consumed by a monitor that compares
// every write the DUT issues.
// ---------------------------------------------------------------------------
module tb_game_sequencer;
  import game_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_sequencer_if #(.IDX_W(7)) bus();

  game_sequencer #(
    .BRICKS(128), .IDX_W(7), .SERVE_FRAMES(60), .LOSS_FRAMES(90),
    .BALL_Y_LOSS(232), .MAX_LEVEL(15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int exp_idx_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: each clear write must match the next queued index.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.clr_we === 1'b1) begin
      check("clr_write_expected", 32'(exp_idx_q.size() != 0), 1);
      if (exp_idx_q.size() != 0) check("clr_idx", 32'(bus.clr_idx), exp_idx_q.pop_front());
    end
  end

  task automatic push_refill();
    for (int i = 0; i < 128; i++) exp_idx_q.push_back(i);
  endtask

  // Drive one clock of inputs starting at a falling edge; pulses drop after.
  task automatic drive(input bit tick, input bit f, input bit hit, input int y);
    bus.frame_tick = tick;
    bus.fire       = f;
    bus.brick_hit  = hit;
    bus.ball_y     = 9'(y);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.brick_hit  = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] exp, input int max_cycles, input string tag);
    int k = 0;
    while (bus.state !== exp && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(bus.state), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.fire       = 1'b0;
    bus.brick_hit  = 1'b0;
    bus.ball_y     = '0;
    bus.lives      = 4'd3;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_state", 32'(bus.state), 32'(IDLE));
    check("rst_clr_we", 32'(bus.clr_we), 0);
    check("rst_clr_idx", 32'(bus.clr_idx), 0);
    check("rst_ball_run", 32'(bus.ball_run), 0);
    check("rst_ball_load", 32'(bus.ball_load), 1);
    check("rst_declives", 32'(bus.declives), 0);
    check("rst_reset_stats", 32'(bus.reset_stats), 0);
    check("rst_level", 32'(bus.level), 0);
    reset = 1'b0;
    @(negedge clk);

    // Start needs fire together with a frame tick
    drive(0, 1, 0, 0);
    check("idle_fire_no_tick", 32'(bus.state), 32'(IDLE));
    push_refill();
    drive(1, 1, 0, 0);
    bus.fire = 1'b0;
    check("start_reset_stats", 32'(bus.reset_stats), 1);
    check("start_state", 32'(bus.state), 32'(CLEAR));
    check("start_clr_we", 32'(bus.clr_we), 1);
    @(negedge clk);
    check("reset_stats_one_clk", 32'(bus.reset_stats), 0);
    repeat (126) @(negedge clk);
    check("clr_last_idx", 32'(bus.clr_idx), 127);
    check("clr_last_we", 32'(bus.clr_we), 1);
    @(negedge clk);
    check("clr_end_we", 32'(bus.clr_we), 0);
    check("clr_end_idx", 32'(bus.clr_idx), 0);
    check("clr_end_state", 32'(bus.state), 32'(SERVE));
    check("clr_all_written", 32'(exp_idx_q.size()), 0);
    check("serve_ball_load", 32'(bus.ball_load), 1);
    check("serve_ball_run", 32'(bus.ball_run), 0);

    // Serve timeout after exactly 60 ticks
    repeat (59) drive(1, 0, 0, 0);
    check("serve_59", 32'(bus.state), 32'(SERVE));
    drive(1, 0, 0, 0);
    check("serve_60_state", 32'(bus.state), 32'(PLAY));
    check("play_ball_run", 32'(bus.ball_run), 1);
    check("play_ball_load", 32'(bus.ball_load), 0);

    // Loss line boundary: 231 stays, 232 loses a ball
    drive(1, 0, 0, 231);
    check("y231_state", 32'(bus.state), 32'(PLAY));
    check("y231_declives", 32'(bus.declives), 0);
    drive(1, 0, 0, 232);
    check("y232_declives", 32'(bus.declives), 1);
    check("y232_state", 32'(bus.state), 32'(LOST));
    check("lost_ball_run", 32'(bus.ball_run), 0);
    check("lost_ball_load", 32'(bus.ball_load), 0);
    bus.ball_y = '0;
    @(negedge clk);
    check("declives_one_clk", 32'(bus.declives), 0);
    repeat (89) drive(1, 0, 0, 0);
    check("lost_89", 32'(bus.state), 32'(LOST));
    drive(1, 0, 0, 0);
    check("lost_90_state", 32'(bus.state), 32'(SERVE));

    // Hit outside PLAY is ignored; early serve on the 3rd tick
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    check("early_serve_2", 32'(bus.state), 32'(SERVE));
    drive(1, 1, 0, 0);
    check("early_serve_3", 32'(bus.state), 32'(PLAY));

    // Level clear after exactly 128 hits
    repeat (127) drive(0, 0, 1, 0);
    check("hits_127_state", 32'(bus.state), 32'(PLAY));
    push_refill();
    drive(0, 0, 1, 0);
    check("hit_128_state", 32'(bus.state), 32'(CLEAR));
    check("hit_128_level", 32'(bus.level), 1);
    check("hit_128_clr_we", 32'(bus.clr_we), 1);
    wait_state(SERVE, 200, "refill2_done");
    check("refill2_all_written", 32'(exp_idx_q.size()), 0);

    // Last brick and loss on the same cycle: clear wins
    drive(1, 1, 0, 0);
    check("serve_fire", 32'(bus.state), 32'(PLAY));
    repeat (127) drive(0, 0, 1, 0);
    push_refill();
    drive(1, 0, 1, 240);
    check("tie_state", 32'(bus.state), 32'(CLEAR));
    check("tie_declives", 32'(bus.declives), 0);
    check("tie_level", 32'(bus.level), 2);
    bus.ball_y = '0;
    @(negedge clk);
    check("tie_declives_after", 32'(bus.declives), 0);
    wait_state(SERVE, 200, "refill3_done");
    check("refill3_all_written", 32'(exp_idx_q.size()), 0);

    // Last life lost, then game over release/press sequence
    drive(1, 1, 0, 0);
    bus.lives = 4'd0;
    drive(1, 0, 0, 240);
    check("last_life_declives", 32'(bus.declives), 1);
    check("last_life_state", 32'(bus.state), 32'(LOST));
    repeat (89) drive(1, 0, 0, 0);
    check("last_lost_89", 32'(bus.state), 32'(LOST));
    drive(1, 0, 0, 0);
    check("over_state", 32'(bus.state), 32'(OVER));
    check("over_ball_run", 32'(bus.ball_run), 0);
    repeat (3) drive(1, 1, 0, 0);
    check("over_held_fire", 32'(bus.state), 32'(OVER));
    drive(1, 0, 0, 0);
    check("over_release", 32'(bus.state), 32'(OVER));
    drive(1, 1, 0, 0);
    check("over_press", 32'(bus.state), 32'(IDLE));

    // Reset in the middle of a refill, then a full refill on restart
    bus.lives = 4'd3;
    push_refill();
    drive(1, 1, 0, 0);
    bus.fire = 1'b0;
    check("restart_state", 32'(bus.state), 32'(CLEAR));
    check("restart_reset_stats", 32'(bus.reset_stats), 1);
    k = 0;
    while (bus.clr_idx !== 7'd50 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reached_idx50", 32'(bus.clr_idx), 50);
    reset = 1'b1;
    #1;
    check("async_rst_clr_we", 32'(bus.clr_we), 0);
    check("async_rst_state", 32'(bus.state), 32'(IDLE));
    check("async_rst_level", 32'(bus.level), 0);
    exp_idx_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_refill();
    drive(1, 1, 0, 0);
    bus.fire = 1'b0;
    wait_state(SERVE, 200, "refill4_done");
    check("refill4_all_written", 32'(exp_idx_q.size()), 0);
    check("refill4_level", 32'(bus.level), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
